// File: rtl/proc_run_controller.sv
// Run/reset sequencer for the processor core: stretches reset, then gates execution
// through a registered clock-enable in bounded, free-run or single-step mode.
module proc_run_controller #(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cycle_limit,
  input  logic             step,
  input  logic             abort,
  input  logic             soft_rst,
  input  logic             halt_i,
  output logic             core_rst,
  output logic             core_en,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    HOLD,
    IDLE,
    RUN,
    STEP,
    DONE
  } state_t;

  localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              bounded;
  logic [CNT_W-1:0]  limit;

  // Saturating increment: the counter sticks at all-ones in long free runs.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic logic limit_hit(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] nxt;
    nxt = {1'b0, cnt} + (CNT_W + 1)'(1);
    return nxt == {1'b0, lim};
  endfunction

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      state    <= HOLD;
      hold_cnt <= '0;
      core_rst <= 1'b1;
      core_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      halted   <= 1'b0;
      if (rst)
        cycle_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            core_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end

        IDLE, DONE: begin
          if (start) begin
            cycle_count <= '0;
            halted      <= 1'b0;
            done        <= 1'b0;
            limit       <= cycle_limit;
            bounded     <= (mode != 2'd1) && (mode != 2'd2);
            if ((mode != 2'd1) && (mode != 2'd2) && (cycle_limit == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode == 2'd2) begin
              state <= STEP;
              busy  <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              core_en <= 1'b1;
            end
          end
        end

        RUN, STEP: begin
          if (abort) begin
            // Abort freezes the count at its current value.
            state   <= IDLE;
            core_en <= 1'b0;
            busy    <= 1'b0;
          end else begin
            if (core_en)
              cycle_count <= sat_inc(cycle_count);
            if (core_en && halt_i) begin
              state   <= DONE;
              core_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              halted  <= 1'b1;
            end else if ((state == RUN) && bounded && core_en &&
                         limit_hit(cycle_count, limit)) begin
              state   <= DONE;
              core_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else if (state == STEP) begin
              core_en <= step;
            end
          end
        end

        default: begin
          state    <= HOLD;
          hold_cnt <= '0;
          core_rst <= 1'b1;
          core_en  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
// Bench for proc_run_controller: vector table plus hand-built multi-cycle sequences,
// with a second 4-bit-counter instance for the saturation case.
module tb_proc_run_controller;

  logic        clk = 1'b0;
  logic        rst, start, step, abort, soft_rst, halt_i;
  logic [1:0]  mode;
  logic [15:0] cycle_limit;
  logic        core_rst, core_en, busy, done, halted;
  logic [15:0] cycle_count;
  logic        core_rst4, core_en4, busy4, done4, halted4;
  logic [3:0]  cycle_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_run_controller #(.RST_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cycle_limit(cycle_limit),
    .step(step), .abort(abort), .soft_rst(soft_rst), .halt_i(halt_i),
    .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done),
    .halted(halted), .cycle_count(cycle_count)
  );

  proc_run_controller #(.RST_CYCLES(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cycle_limit(cycle_limit[3:0]),
    .step(step), .abort(abort), .soft_rst(soft_rst), .halt_i(halt_i),
    .core_rst(core_rst4), .core_en(core_en4), .busy(busy4), .done(done4),
    .halted(halted4), .cycle_count(cycle_count4)
  );

  typedef struct {
    logic        rst, start;
    logic [1:0]  mode;
    logic [15:0] lim;
    logic        stp, abt, srst, hlt;
    logic        er, ee, eb, ed, eh;
    logic [15:0] ec;
  } vec_t;

  vec_t sbq[$];
  vec_t tbl[19];

  function automatic vec_t mk(input logic r, input logic s, input logic [1:0] m,
                              input logic [15:0] l, input logic st, input logic ab,
                              input logic sr, input logic h, input logic er,
                              input logic ee, input logic eb, input logic ed,
                              input logic eh, input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.lim = l;
    v.stp = st; v.abt = ab; v.srst = sr; v.hlt = h;
    v.er = er; v.ee = ee; v.eb = eb; v.ed = ed; v.eh = eh; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string nm);
    vec_t e;
    rst = v.rst; start = v.start; mode = v.mode; cycle_limit = v.lim;
    step = v.stp; abort = v.abt; soft_rst = v.srst; halt_i = v.hlt;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check({nm, ".core_rst"}, 32'(core_rst), 32'(e.er));
    check({nm, ".core_en"}, 32'(core_en), 32'(e.ee));
    check({nm, ".busy"}, 32'(busy), 32'(e.eb));
    check({nm, ".done"}, 32'(done), 32'(e.ed));
    check({nm, ".halted"}, 32'(halted), 32'(e.eh));
    check({nm, ".cycle_count"}, 32'(cycle_count), 32'(e.ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_prev;
    logic st;
    int   cnt;

    rst = 1'b1; start = 1'b0; mode = 2'd0; cycle_limit = '0;
    step = 1'b0; abort = 1'b0; soft_rst = 1'b0; halt_i = 1'b0;

    // Reset hold with start ignored, zero budget, mode 3, short step, abort.
    tbl[0]  = mk(1,0,0,0,  0,0,0,0, 1,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,0,  0,0,0,0, 1,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,0,  0,0,0,0, 1,0,0,0,0,0);
    tbl[3]  = mk(0,1,0,3,  0,0,0,0, 1,0,0,0,0,0);
    tbl[4]  = mk(0,1,0,3,  0,0,0,0, 1,0,0,0,0,0);
    tbl[5]  = mk(0,1,0,3,  0,0,0,0, 1,0,0,0,0,0);
    tbl[6]  = mk(0,1,0,3,  0,0,0,0, 0,0,0,0,0,0);
    tbl[7]  = mk(0,0,0,0,  0,0,0,0, 0,0,0,0,0,0);
    tbl[8]  = mk(0,1,0,0,  0,0,0,0, 0,0,0,1,0,0);
    tbl[9]  = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0,0);
    tbl[10] = mk(0,1,3,2,  0,0,0,0, 0,1,1,0,0,0);
    tbl[11] = mk(0,0,0,0,  0,0,0,0, 0,1,1,0,0,1);
    tbl[12] = mk(0,0,0,0,  0,0,0,0, 0,0,0,1,0,2);
    tbl[13] = mk(0,1,2,0,  0,0,0,0, 0,0,1,0,0,0);
    tbl[14] = mk(0,0,0,0,  1,0,0,0, 0,1,1,0,0,0);
    tbl[15] = mk(0,0,0,0,  0,0,0,0, 0,0,1,0,0,1);
    tbl[16] = mk(0,0,0,0,  0,1,0,0, 0,0,0,0,0,1);
    tbl[17] = mk(0,0,0,0,  0,1,0,0, 0,0,0,0,0,1);
    tbl[18] = mk(0,0,0,0,  0,0,0,1, 0,0,0,0,0,1);
    for (int i = 0; i < 19; i++)
      apply(tbl[i], $sformatf("tbl%0d", i));

    // Bounded run of 10, twice.
    for (int rep = 0; rep < 2; rep++) begin
      apply(mk(0,1,0,10, 0,0,0,0, 0,1,1,0,0,0), "bnd.start");
      for (int i = 1; i <= 10; i++)
        apply(mk(0,0,0,0, 0,0,0,0, 0,(i<10),(i<10),(i==10),0,16'(i)),
              $sformatf("bnd%0d.c%0d", rep, i));
    end

    // Free-run halted on the 7th enabled cycle.
    apply(mk(0,1,1,0, 0,0,0,0, 0,1,1,0,0,0), "fhalt.start");
    for (int i = 1; i <= 7; i++)
      apply(mk(0,0,0,0, 0,0,0,(i==7), 0,(i<7),(i<7),(i==7),(i==7),16'(i)),
            $sformatf("fhalt.c%0d", i));

    // Halt coinciding with the last budgeted cycle.
    apply(mk(0,1,0,5, 0,0,0,0, 0,1,1,0,0,0), "hlim.start");
    for (int i = 1; i <= 5; i++)
      apply(mk(0,0,0,0, 0,0,0,(i==5), 0,(i<5),(i<5),(i==5),(i==5),16'(i)),
            $sformatf("hlim.c%0d", i));

    // Single-step: pulses on cycles 3, 4, 9; budget ignored.
    apply(mk(0,1,2,1, 0,0,0,0, 0,0,1,0,0,0), "step.start");
    en_prev = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      st = (c == 3) || (c == 4) || (c == 9);
      if (en_prev) cnt++;
      en_prev = st;
      apply(mk(0,0,0,0, st,0,0,0, 0,st,1,0,0,16'(cnt)), $sformatf("step.c%0d", c));
    end
    apply(mk(0,0,0,0, 0,1,0,0, 0,0,0,0,0,3), "step.abort");

    // Free-run 20 then soft reset: count kept, reset stretched.
    apply(mk(0,1,1,0, 0,0,0,0, 0,1,1,0,0,0), "srst.start");
    for (int i = 1; i <= 20; i++)
      apply(mk(0,0,0,0, 0,0,0,0, 0,1,1,0,0,16'(i)), $sformatf("srst.c%0d", i));
    apply(mk(0,0,0,0, 0,0,1,0, 1,0,0,0,0,20), "srst.assert");
    for (int k = 1; k <= 4; k++)
      apply(mk(0,0,0,0, 0,0,0,0, (k<4),0,0,0,0,20), $sformatf("srst.hold%0d", k));

    // Same with global reset: count clears.
    apply(mk(0,1,1,0, 0,0,0,0, 0,1,1,0,0,0), "grst.start");
    for (int i = 1; i <= 5; i++)
      apply(mk(0,0,0,0, 0,0,0,0, 0,1,1,0,0,16'(i)), $sformatf("grst.c%0d", i));
    apply(mk(1,0,0,0, 0,0,0,0, 1,0,0,0,0,0), "grst.assert");
    for (int k = 1; k <= 4; k++)
      apply(mk(0,0,0,0, 0,0,0,0, (k<4),0,0,0,0,0), $sformatf("grst.hold%0d", k));

    // Saturation on the 4-bit instance.
    apply(mk(0,1,1,0, 0,0,0,0, 0,1,1,0,0,0), "sat.start");
    for (int i = 1; i <= 20; i++) begin
      apply(mk(0,0,0,0, 0,0,0,0, 0,1,1,0,0,16'(i)), $sformatf("sat.c%0d", i));
      check($sformatf("sat4.cnt%0d", i), 32'(cycle_count4), (i < 15) ? i : 15);
    end
    apply(mk(0,0,0,0, 0,1,0,0, 0,0,0,0,0,20), "sat.abort");
    check("sat4.held", 32'(cycle_count4), 15);
    check("sat4.busy", 32'(busy4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_run_controller.md
Name: proc_run_controller

Overview:
- Synthesizable run/reset sequencer that sits between the board clock/reset and the Processor core.
- Stretches reset to the core for a parametrised number of cycles, then gates core execution through a clock-enable.
- Three run modes: bounded (stops after a programmable cycle budget), free-run, and single-step.
- Reports completion, the core halt, and the count of executed cycles, so benches and on-chip debug no longer hard-code cycle counts.

Parameters:
- RST_CYCLES, 4: number of cycles core_rst is held high after rst (or soft_rst) is released; minimum 1.
- CNT_W, 16: width of the cycle budget and the cycle counter.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: begin a run in the selected mode.
- mode  input  2  sampled on start. 0 = bounded, 1 = free-run, 2 = single-step, 3 = reserved (treated as 0).
- cycle_limit  input  CNT_W  enabled-cycle budget for bounded mode; sampled on start.
- step  input  1  in step mode, each cycle step=1 grants one enabled core cycle.
- abort  input  1  stop the run and return to IDLE.
- soft_rst  input  1  re-enter reset hold without a global rst.
- halt_i  input  1  halt indication from the core; only meaningful while core_en=1.
- core_rst  output  1  registered, active-high reset to the core.
- core_en  output  1  registered clock-enable to the core.
- busy  output  1  high in RUN and STEP.
- done  output  1  sticky high in DONE.
- halted  output  1  sticky; the run ended because of halt_i.
- cycle_count  output  CNT_W  number of enabled cycles in the current run.

Behaviour:
- States: HOLD, IDLE, RUN, STEP, DONE. All outputs are registered and updated on the same edge as the state.
- Reset (rst=1): state=HOLD, hold counter=0, core_rst=1, core_en=0, busy=0, done=0, halted=0, cycle_count=0.
- HOLD:
  - core_rst=1 and the hold counter increments each cycle.
  - After RST_CYCLES cycles with rst=0, go to IDLE and set core_rst=0 on that edge.
  - start is ignored in HOLD.
- IDLE:
  - core_en=0.
  - On start: clear cycle_count and halted, latch mode and cycle_limit.
  - mode 0/3 with limit=0 goes straight to DONE with zero enabled cycles.
  - Otherwise mode 0/1/3 goes to RUN and mode 2 goes to STEP.
- RUN:
  - core_en=1 every cycle, and cycle_count increments on each edge where core_en=1.
  - Bounded mode: on the edge where core_en=1 and cycle_count+1 == limit, go to DONE with core_en=0. This gives exactly `limit` enabled cycles.
  - Free-run: cycle_count saturates at all-ones and never wraps.
- STEP:
  - core_en(next) = step. Each cycle step=1 yields exactly one enabled cycle on the following cycle.
  - cycle_count counts those cycles.
  - The cycle budget is ignored in step mode.
- halt_i:
  - Sampled only while core_en=1. That cycle still counts.
  - Next state is DONE with halted=1.
  - halt_i while core_en=0 is ignored.
- DONE:
  - done=1, core_en=0, busy=0; cycle_count is held.
  - start re-launches exactly as from IDLE and clears done.
- abort:
  - In RUN or STEP, next state is IDLE with core_en=0 and cycle_count retained.
  - In other states abort is ignored.
- soft_rst: from any state, next state is HOLD with the same effects as rst, except cycle_count is retained.
- Priority on simultaneous events: rst > soft_rst > abort > halt_i > limit reached > start/step.
  - halt_i together with limit reached: DONE, halted=1.
  - start in RUN or STEP is ignored.
- busy is high exactly in RUN and STEP. core_en=1 implies busy=1 and core_rst=0.

Test Plan:
- Reset hold: RST_CYCLES=4, rst high 3 cycles then low -> core_rst stays high exactly 4 more cycles, then falls. Issue start during the hold -> it is ignored.
- Bounded run: mode=0, cycle_limit=10, start -> core_en high exactly 10 consecutive cycles, then done=1, cycle_count=10, halted=0. A second start gives another 10 cycles with cycle_count restarting at 1.
- Zero budget and halt: mode=0, limit=0 -> done=1 one cycle after start with zero enabled cycles. mode=1 with halt_i on the 7th enabled cycle -> done=1, halted=1, cycle_count=7. halt_i and limit reached together -> halted=1.
- Single-step: mode=2; step pulses at cycles 3, 4 and 9 -> core_en high on cycles 4, 5 and 10 only, cycle_count=3. Then abort -> IDLE with the count held at 3.
- Mid-run reset: free-run for 20 cycles, then soft_rst -> core_en drops next edge, core_rst high for RST_CYCLES cycles, cycle_count stays 20. Repeat with rst -> cycle_count clears to 0.
- Saturation: CNT_W=4, mode=1, run 20 cycles -> cycle_count stops at 15 and never wraps.
